// File: rtl/poly_frontend_dbuf_pkg.sv
// Shared constants for the SPI scene-loading frontend: register map,
// frame FSM encoding and the polygon-slot address decoder.
package poly_frontend_dbuf_pkg;

  localparam int WPX_DEF    = 8;
  localparam int WPY_DEF    = 8;
  localparam int WCOLOR_DEF = 8;

  localparam logic [6:0] ADDR_BG     = 7'h00;
  localparam logic [6:0] ADDR_EN_LO  = 7'h01;
  localparam logic [6:0] ADDR_EN_HI  = 7'h02;
  localparam logic [6:0] POLY_BASE   = 7'h04;
  localparam logic [6:0] POLY_STRIDE = 7'h08;

  localparam logic [2:0] F_COLOR = 3'd0;
  localparam logic [2:0] F_V0X   = 3'd1;
  localparam logic [2:0] F_V0Y   = 3'd2;
  localparam logic [2:0] F_V1X   = 3'd3;
  localparam logic [2:0] F_V1Y   = 3'd4;
  localparam logic [2:0] F_V2X   = 3'd5;
  localparam logic [2:0] F_V2Y   = 3'd6;

  localparam int CMD_WRITE = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
    logic [2:0] fld;
  } poly_sel_t;

  // Offset 7 of each slot decodes as a hit but matches no field, so it reads 0.
  function automatic poly_sel_t poly_decode(input logic [6:0] a, input int n_poly);
    poly_sel_t  s;
    logic [6:0] off;
    off   = a - POLY_BASE;
    s.idx = 4'(off / POLY_STRIDE);
    s.fld = 3'(off % POLY_STRIDE);
    s.hit = (a >= POLY_BASE) && (int'(s.idx) < n_poly);
    return s;
  endfunction

endpackage

// File: rtl/poly_frontend_dbuf_spi_byte_slave.sv
// Mode-0 SPI byte slave: synchronises the pins into clk, runs the
// IDLE/CMD/DATA frame FSM and exchanges whole bytes with the register map.
module spi_byte_slave
  import poly_frontend_dbuf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_in,
  input  logic       sck_in,
  input  logic       mosi_in,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       miso,
  output logic       byte_valid,
  output logic       byte_is_cmd,
  output logic [7:0] rx_byte,
  output logic       frame_start,
  output logic       busy
);

  logic [1:0] cs_sync, sck_sync, mosi_sync;
  logic       cs_d, sck_d;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [6:0] shin;
  logic [7:0] tx;
  logic       cs_rise, cs_fall, sck_rise, sck_fall;

  assign cs_rise  =  cs_sync[1] & ~cs_d;
  assign cs_fall  = ~cs_sync[1] &  cs_d;
  assign sck_rise =  sck_sync[1] & ~sck_d;
  assign sck_fall = ~sck_sync[1] &  sck_d;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync     <= '0;
      sck_sync    <= '0;
      mosi_sync   <= '0;
      cs_d        <= 1'b0;
      sck_d       <= 1'b0;
      state       <= ST_IDLE;
      cnt         <= '0;
      shin        <= '0;
      tx          <= '0;
      miso        <= 1'b0;
      byte_valid  <= 1'b0;
      byte_is_cmd <= 1'b0;
      rx_byte     <= '0;
      frame_start <= 1'b0;
    end else begin
      cs_sync     <= {cs_sync[0], cs_in};
      sck_sync    <= {sck_sync[0], sck_in};
      mosi_sync   <= {mosi_sync[0], mosi_in};
      cs_d        <= cs_sync[1];
      sck_d       <= sck_sync[1];
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      if (load) tx <= load_byte;
      // A CS edge overrides any SCK activity, so a partial byte is simply lost.
      if (cs_rise) begin
        state <= ST_IDLE;
        cnt   <= '0;
        tx    <= '0;
        miso  <= 1'b0;
      end else if (cs_fall) begin
        state       <= ST_CMD;
        cnt         <= '0;
        tx          <= '0;
        miso        <= 1'b0;
        frame_start <= 1'b1;
      end else if (state != ST_IDLE) begin
        if (sck_rise) begin
          shin <= {shin[5:0], mosi_sync[1]};
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_byte     <= {shin, mosi_sync[1]};
            byte_valid  <= 1'b1;
            byte_is_cmd <= (state == ST_CMD);
            state       <= ST_DATA;
          end
        end
        if (sck_fall) begin
          miso <= tx[7];
          tx   <= {tx[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/poly_frontend_dbuf.sv
// Double-buffered scene register bank loaded over SPI; en_load copies the
// shadow bank to the active bank, deferred while an SPI frame is in flight.
module poly_frontend_dbuf
  import poly_frontend_dbuf_pkg::*;
#(
  parameter int N_POLY = 3,
  parameter int WPX    = WPX_DEF,
  parameter int WPY    = WPY_DEF,
  parameter int WCOLOR = WCOLOR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs_in,
  input  logic                     sck_in,
  input  logic                     mosi_in,
  output logic                     miso_out,
  input  logic                     en_load,
  output logic [WCOLOR-1:0]        bg_color_out,
  output logic [WCOLOR*N_POLY-1:0] poly_color_out,
  output logic [WPX*N_POLY-1:0]    v0_x_out,
  output logic [WPX*N_POLY-1:0]    v1_x_out,
  output logic [WPX*N_POLY-1:0]    v2_x_out,
  output logic [WPY*N_POLY-1:0]    v0_y_out,
  output logic [WPY*N_POLY-1:0]    v1_y_out,
  output logic [WPY*N_POLY-1:0]    v2_y_out,
  output logic [N_POLY-1:0]        poly_enable_out,
  output logic                     commit_pending_out
);

  logic                             byte_valid, byte_is_cmd, frame_start, frame_busy;
  logic [7:0]                       rx_byte, rd_data;
  logic                             load;
  logic [6:0]                       addr, next_addr;
  logic                             wr;
  poly_sel_t                        wsel, rsel;

  logic [WCOLOR-1:0]                sh_bg, act_bg;
  logic [N_POLY-1:0]                sh_en, act_en;
  logic [N_POLY-1:0][WCOLOR-1:0]    sh_color, act_color;
  logic [2:0][N_POLY-1:0][WPX-1:0]  sh_vx, act_vx;
  logic [2:0][N_POLY-1:0][WPY-1:0]  sh_vy, act_vy;

  spi_byte_slave u_spi (
    .clk         (clk),
    .rst         (rst),
    .cs_in       (cs_in),
    .sck_in      (sck_in),
    .mosi_in     (mosi_in),
    .load        (load),
    .load_byte   (rd_data),
    .miso        (miso_out),
    .byte_valid  (byte_valid),
    .byte_is_cmd (byte_is_cmd),
    .rx_byte     (rx_byte),
    .frame_start (frame_start),
    .busy        (frame_busy)
  );

  // Readback is staged for the address the next byte will cover.
  assign next_addr = byte_is_cmd ? rx_byte[6:0] : addr + 7'd1;
  assign load      = byte_valid && (byte_is_cmd ? !rx_byte[CMD_WRITE] : !wr);
  assign wsel      = poly_decode(addr, N_POLY);
  assign rsel      = poly_decode(next_addr, N_POLY);

  always_comb begin
    rd_data = '0;
    if (next_addr == ADDR_BG) rd_data = 8'(sh_bg);
    for (int i = 0; i < N_POLY; i++) begin
      if ((next_addr == ADDR_EN_LO && i < 8) || (next_addr == ADDR_EN_HI && i >= 8))
        rd_data[3'(i)] = sh_en[i];
      if (rsel.hit && int'(rsel.idx) == i) begin
        case (rsel.fld)
          F_COLOR: rd_data = 8'(sh_color[i]);
          F_V0X:   rd_data = 8'(sh_vx[0][i]);
          F_V0Y:   rd_data = 8'(sh_vy[0][i]);
          F_V1X:   rd_data = 8'(sh_vx[1][i]);
          F_V1Y:   rd_data = 8'(sh_vy[1][i]);
          F_V2X:   rd_data = 8'(sh_vx[2][i]);
          F_V2Y:   rd_data = 8'(sh_vy[2][i]);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      wr       <= 1'b0;
      sh_bg    <= '0;
      sh_en    <= '0;
      sh_color <= '0;
      sh_vx    <= '0;
      sh_vy    <= '0;
    end else begin
      if (frame_start) begin
        addr <= '0;
        wr   <= 1'b0;
      end
      if (byte_valid && byte_is_cmd) begin
        wr   <= rx_byte[CMD_WRITE];
        addr <= rx_byte[6:0];
      end else if (byte_valid) begin
        addr <= addr + 7'd1;
        if (wr) begin
          if (addr == ADDR_BG) sh_bg <= rx_byte[WCOLOR-1:0];
          for (int i = 0; i < N_POLY; i++) begin
            if ((addr == ADDR_EN_LO && i < 8) || (addr == ADDR_EN_HI && i >= 8))
              sh_en[i] <= rx_byte[3'(i)];
            if (wsel.hit && int'(wsel.idx) == i) begin
              case (wsel.fld)
                F_COLOR: sh_color[i] <= rx_byte[WCOLOR-1:0];
                F_V0X:   sh_vx[0][i] <= rx_byte[WPX-1:0];
                F_V0Y:   sh_vy[0][i] <= rx_byte[WPY-1:0];
                F_V1X:   sh_vx[1][i] <= rx_byte[WPX-1:0];
                F_V1Y:   sh_vy[1][i] <= rx_byte[WPY-1:0];
                F_V2X:   sh_vx[2][i] <= rx_byte[WPX-1:0];
                F_V2Y:   sh_vy[2][i] <= rx_byte[WPY-1:0];
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  // byte_valid lags the FSM by a cycle, so it also counts as in-flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending_out <= 1'b0;
      act_bg             <= '0;
      act_en             <= '0;
      act_color          <= '0;
      act_vx             <= '0;
      act_vy             <= '0;
    end else if (en_load && (frame_busy || byte_valid)) begin
      commit_pending_out <= 1'b1;
    end else if (!(frame_busy || byte_valid) && (en_load || commit_pending_out)) begin
      commit_pending_out <= 1'b0;
      act_bg             <= sh_bg;
      act_en             <= sh_en;
      act_color          <= sh_color;
      act_vx             <= sh_vx;
      act_vy             <= sh_vy;
    end
  end

  assign bg_color_out    = act_bg;
  assign poly_enable_out = act_en;
  assign poly_color_out  = act_color;
  assign v0_x_out        = act_vx[0];
  assign v1_x_out        = act_vx[1];
  assign v2_x_out        = act_vx[2];
  assign v0_y_out        = act_vy[0];
  assign v1_y_out        = act_vy[1];
  assign v2_y_out        = act_vy[2];

endmodule

// File: tb/tb_poly_frontend_dbuf.sv
// Directed bench for poly_frontend_dbuf: bit-banged SPI frames, commits
// and readback, with hand-computed expectations.
module tb_poly_frontend_dbuf;

  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rst, cs, sck, mosi, en_load;
  logic          miso, pending;
  logic [7:0]    bg;
  logic [8*NP-1:0] color, v0x, v1x, v2x, v0y, v1y, v2y;
  logic [NP-1:0] enable;
  logic [7:0]    r;
  int            passed = 0;
  int            total  = 0;

  always #5 clk = ~clk;

  poly_frontend_dbuf #(.N_POLY(NP), .WPX(8), .WPY(8), .WCOLOR(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .cs_in              (cs),
    .sck_in             (sck),
    .mosi_in            (mosi),
    .miso_out           (miso),
    .en_load            (en_load),
    .bg_color_out       (bg),
    .poly_color_out     (color),
    .v0_x_out           (v0x),
    .v1_x_out           (v1x),
    .v2_x_out           (v2x),
    .v0_y_out           (v0y),
    .v1_y_out           (v1y),
    .v2_y_out           (v2y),
    .poly_enable_out    (enable),
    .commit_pending_out (pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // SCK period is 16 clk; MISO is sampled at each rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #80 sck = 1'b1;
      rx[i] = miso;
      #80 sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    #160;
  endtask

  task automatic cs_end();
    #160 cs = 1'b1;
    #240;
  endtask

  task automatic pulse_load();
    @(negedge clk) en_load = 1'b1;
    @(negedge clk) en_load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; en_load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_bg", 32'(bg), 32'h0);
    check("rst_color", 32'(color), 32'h0);
    check("rst_v0x", 32'(v0x), 32'h0);
    check("rst_enable", 32'(enable), 32'h0);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    pulse_load();
    check("load0_color", 32'(color), 32'h0);
    check("load0_pending", 32'(pending), 32'h0);

    // Polygon 0 record, then enable bit 0.
    cs_begin();
    spi_byte(8'h84, r);
    spi_byte(8'h2A, r);
    check("miso_write_frame", 32'(r), 32'h0);
    spi_byte(8'h05, r); spi_byte(8'h06, r); spi_byte(8'h07, r);
    spi_byte(8'h08, r); spi_byte(8'h09, r); spi_byte(8'h0A, r);
    cs_end();
    cs_begin();
    spi_byte(8'h81, r);
    spi_byte(8'h01, r);
    cs_end();
    check("pre_load_color", 32'(color), 32'h0);
    check("pre_load_enable", 32'(enable), 32'h0);
    pulse_load();
    check("p0_color", 32'(color), 32'h00002A);
    check("p0_v0x", 32'(v0x), 32'h000005);
    check("p0_v0y", 32'(v0y), 32'h000006);
    check("p0_v1x", 32'(v1x), 32'h000007);
    check("p0_v1y", 32'(v1y), 32'h000008);
    check("p0_v2x", 32'(v2x), 32'h000009);
    check("p0_v2y", 32'(v2y), 32'h00000A);
    check("p0_enable", 32'(enable), 32'h1);

    // Readback from 0x04 with two dummy bytes.
    cs_begin();
    spi_byte(8'h04, r);
    spi_byte(8'h00, r);
    check("rd_0x04", 32'(r), 32'h2A);
    spi_byte(8'h00, r);
    check("rd_0x05", 32'(r), 32'h05);
    cs_end();
    check("rd_active_kept", 32'(color), 32'h00002A);
    check("miso_idle", 32'(miso), 32'h0);

    // Commit requested mid-frame is deferred to the cycle after CS rises.
    cs_begin();
    spi_byte(8'h8C, r);
    spi_byte(8'h33, r);
    pulse_load();
    check("defer_pending", 32'(pending), 32'h1);
    check("defer_color_old", 32'(color), 32'h00002A);
    spi_byte(8'h11, r);
    #160;
    @(negedge clk) cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("defer_still_old", 32'(color), 32'h00002A);
    check("defer_still_pending", 32'(pending), 32'h1);
    @(posedge clk);
    #1;
    check("defer_color_new", 32'(color), 32'h00332A);
    check("defer_v0x_new", 32'(v0x), 32'h001105);
    check("defer_pending_clr", 32'(pending), 32'h0);
    @(negedge clk);
    #200;

    // Partial byte is dropped; the following frames decode normally.
    cs_begin();
    spi_byte(8'h84, r);
    spi_bits(8'hFF, 5, r);
    cs_end();
    cs_begin();
    spi_byte(8'h04, r);
    spi_byte(8'h00, r);
    cs_end();
    check("partial_dropped", 32'(r), 32'h2A);
    cs_begin();
    spi_byte(8'h86, r);
    spi_byte(8'h44, r);
    cs_end();
    cs_begin();
    spi_byte(8'h06, r);
    spi_byte(8'h00, r);
    cs_end();
    check("after_partial_rd", 32'(r), 32'h44);

    // Address wrap 0x7F -> 0x00 lands on the background colour.
    cs_begin();
    spi_byte(8'hFF, r);
    spi_byte(8'h55, r);
    spi_byte(8'h3C, r);
    cs_end();
    check("wrap_bg_before_load", 32'(bg), 32'h0);
    pulse_load();
    check("wrap_bg", 32'(bg), 32'h3C);
    cs_begin();
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    cs_end();
    check("rd_bg", 32'(r), 32'h3C);

    // Reserved slot and the first address past the last polygon.
    cs_begin();
    spi_byte(8'h83, r);
    spi_byte(8'h77, r);
    cs_end();
    cs_begin();
    spi_byte(8'h9C, r);
    spi_byte(8'h66, r);
    cs_end();
    cs_begin();
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
    check("rd_reserved_0x03", 32'(r), 32'h0);
    cs_end();
    cs_begin();
    spi_byte(8'h1C, r);
    spi_byte(8'h00, r);
    check("rd_unmapped_0x1c", 32'(r), 32'h0);
    cs_end();
    pulse_load();
    check("final_color", 32'(color), 32'h00332A);
    check("final_v0y", 32'(v0y), 32'h000044);
    check("final_enable", 32'(enable), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
